// File: rtl/obi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obi_pkg : OBI configuration record and default A/R channel struct types
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned AddrWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{DataWidth: 32, AddrWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage
`default_nettype wire

// File: rtl/user_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// user_mem_pkg : shared constants, response-stage type and index helper
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package user_mem_pkg;

  localparam int unsigned MaxLatency = 4;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned IdWidth    = obi_pkg::ObiDefaultConfig.IdWidth;

  // Default stage layout; the top re-declares it with its own id width.
  typedef struct packed {
    logic                 valid;
    logic [IdWidth-1:0]   id;
    logic                 err;
    logic [DataWidth-1:0] data;
  } rsp_stage_t;

  function automatic logic [7:0] word_idx(input logic [31:0] addr, input int unsigned num_words);
    return 8'((addr >> 2) & (num_words - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/user_obi_rsp_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// user_obi_rsp_pipe : Latency-deep in-order delay line, cleared on reset
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module user_obi_rsp_pipe
  import user_mem_pkg::*;
#(
  parameter int unsigned Latency = 1,
  parameter type         stage_t = rsp_stage_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  stage_t stage_i,
  output stage_t stage_o
);

  stage_t stage_q [Latency];
  stage_t stage_d [Latency];

  always_comb begin
    stage_d[0] = stage_i;
    for (int i = 1; i < Latency; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q[Latency-1];

endmodule
`default_nettype wire

// File: rtl/user_obi_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// user_obi_mem : OBI scratchpad with byte writes, range check, error counter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module user_obi_mem
  import user_mem_pkg::*;
#(
  parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumWords  = 16,
  parameter int unsigned       Latency   = 1,
  parameter bit                ReadOnly  = 1'b0,
  parameter logic [31:0]       InitWord  = 32'hDEADBEEF,
  parameter int unsigned       CntWidth  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  obi_req_t            obi_req_i,
  output obi_rsp_t            obi_rsp_o,
  output logic [CntWidth-1:0] err_cnt_o,
  input  logic                clr_cnt_i
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned IdW  = ObiCfg.IdWidth;

  if (Latency < 1 || Latency > MaxLatency) begin : g_bad_latency
    $fatal(1, "user_obi_mem: Latency must be 1..%0d", MaxLatency);
  end
  if (NumWords < 2 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_depth
    $fatal(1, "user_obi_mem: NumWords must be a power of two >= 2");
  end
  if (ObiCfg.DataWidth != 32) begin : g_bad_width
    $fatal(1, "user_obi_mem: DataWidth must be 32");
  end

  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
    logic           err;
    logic [31:0]    data;
  } stage_t;

  logic            req_acc;
  logic [IdxW-1:0] idx;
  logic            req_oor;
  logic            req_err;
  logic            unused_a_optional;
  logic [31:0]     mem_q [NumWords];
  logic [31:0]     mem_d [NumWords];
  stage_t          stage_in;
  stage_t          stage_out;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;

  assign unused_a_optional = obi_req_i.a.a_optional;
  assign req_acc = obi_req_i.req & rst_ni;
  assign idx     = IdxW'(word_idx(obi_req_i.a.addr, NumWords));
  // The block sits at offset 0 of its window, so any higher bit is a miss.
  assign req_oor = |(obi_req_i.a.addr >> (IdxW + 2));
  assign req_err = req_oor | (obi_req_i.a.we & ReadOnly);

  always_comb begin
    mem_d = mem_q;
    if (req_acc && obi_req_i.a.we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_req_i.a.be[b]) begin
          mem_d[idx][8*b +: 8] = obi_req_i.a.wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= InitWord;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    stage_in = '0;
    if (req_acc) begin
      stage_in.valid = 1'b1;
      stage_in.id    = IdW'(obi_req_i.a.aid);
      stage_in.err   = req_err;
      stage_in.data  = (!obi_req_i.a.we && !req_err) ? mem_q[idx] : '0;
    end
  end

  user_obi_rsp_pipe #(
    .Latency (Latency),
    .stage_t (stage_t)
  ) i_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stage_i (stage_in),
    .stage_o (stage_out)
  );

  // Stage contents are only trusted once reset has been released.
  always_comb begin
    obi_rsp_o     = '0;
    obi_rsp_o.gnt = obi_req_i.req;
    if (rst_ni) begin
      obi_rsp_o.rvalid  = stage_out.valid;
      obi_rsp_o.r.rdata = stage_out.data;
      obi_rsp_o.r.rid   = 4'(stage_out.id);
      obi_rsp_o.r.err   = stage_out.err;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (obi_rsp_o.rvalid && obi_rsp_o.r.err && cnt_q != '1) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = rst_ni ? cnt_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_user_obi_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_user_obi_mem : directed self-checking bench for three user_obi_mem builds
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_user_obi_mem;
  import obi_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  obi_req_t req_a, req_b, req_c;
  obi_rsp_t rsp_a, rsp_b, rsp_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic     clr_a, clr_b, clr_c;
  int       n_cmp = 0;
  int       n_bad = 0;

  always #5 clk = ~clk;

  // A: RW, Latency 1. B: read-only. C: Latency 3 with a 2-bit counter.
  user_obi_mem #(.NumWords(16), .Latency(1), .ReadOnly(1'b0), .CntWidth(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_a), .obi_rsp_o(rsp_a),
    .err_cnt_o(cnt_a), .clr_cnt_i(clr_a));
  user_obi_mem #(.NumWords(16), .Latency(1), .ReadOnly(1'b1), .CntWidth(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_b), .obi_rsp_o(rsp_b),
    .err_cnt_o(cnt_b), .clr_cnt_i(clr_b));
  user_obi_mem #(.NumWords(16), .Latency(3), .ReadOnly(1'b0), .CntWidth(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req_c), .obi_rsp_o(rsp_c),
    .err_cnt_o(cnt_c), .clr_cnt_i(clr_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic obi_req_t mk(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [3:0] aid);
    obi_req_t r;
    r         = '0;
    r.req     = 1'b1;
    r.a.addr  = addr;
    r.a.we    = we;
    r.a.be    = be;
    r.a.wdata = wdata;
    r.a.aid   = aid;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_a = mk(32'h0, 1'b0, 4'h0, 32'h0, 4'd1);
    req_b = '0;
    req_c = '0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    tick; tick;
    check_eq("rst_gnt_mirror", rsp_a.gnt, 1'b1);
    check_eq("rst_rvalid", rsp_a.rvalid, 1'b0);
    check_eq("rst_rdata", rsp_a.r.rdata, 32'h0);
    check_eq("rst_cnt", cnt_a, 8'd0);
    req_a = '0;
    #1;
    check_eq("gnt_low", rsp_a.gnt, 1'b0);
    rst_n = 1'b1;

    // Reset contents at both ends of the array
    req_a = mk(32'h0, 1'b0, 4'h0, 32'h0, 4'd1); tick;
    check_eq("rd0_rvalid", rsp_a.rvalid, 1'b1);
    check_eq("rd0_rdata", rsp_a.r.rdata, 32'hDEADBEEF);
    check_eq("rd0_err", rsp_a.r.err, 1'b0);
    check_eq("rd0_rid", rsp_a.r.rid, 4'd1);
    req_a = mk(32'h3C, 1'b0, 4'h0, 32'h0, 4'd2); tick;
    check_eq("rd3c_rdata", rsp_a.r.rdata, 32'hDEADBEEF);
    check_eq("rd3c_rid", rsp_a.r.rid, 4'd2);

    // Byte-enabled write then immediate read-back
    req_a = mk(32'h8, 1'b1, 4'b0101, 32'h11223344, 4'd3); tick;
    check_eq("wr8_rvalid", rsp_a.rvalid, 1'b1);
    check_eq("wr8_err", rsp_a.r.err, 1'b0);
    check_eq("wr8_rdata", rsp_a.r.rdata, 32'h0);
    req_a = mk(32'h8, 1'b0, 4'h0, 32'h0, 4'd4); tick;
    check_eq("rd8_merged", rsp_a.r.rdata, 32'hDE22BE44);

    // be=0 write leaves the word alone
    req_a = mk(32'hC, 1'b1, 4'h0, 32'h55667788, 4'd5); tick;
    req_a = mk(32'hC, 1'b0, 4'h0, 32'h0, 4'd6); tick;
    check_eq("rdc_be0", rsp_a.r.rdata, 32'hDEADBEEF);

    // Out-of-range read, then counter update one cycle later
    req_a = mk(32'h40, 1'b0, 4'h0, 32'h0, 4'd7); tick;
    check_eq("oor_err", rsp_a.r.err, 1'b1);
    check_eq("oor_rdata", rsp_a.r.rdata, 32'h0);
    check_eq("oor_cnt_before", cnt_a, 8'd0);
    req_a = '0; tick;
    check_eq("idle_rvalid", rsp_a.rvalid, 1'b0);
    check_eq("oor_cnt_after", cnt_a, 8'd1);

    // Out-of-range write must not alias onto word 2
    req_a = mk(32'h48, 1'b1, 4'hF, 32'hFFFFFFFF, 4'd8); tick;
    check_eq("oorw_err", rsp_a.r.err, 1'b1);
    req_a = mk(32'h8, 1'b0, 4'h0, 32'h0, 4'd9); tick;
    check_eq("oorw_noalias", rsp_a.r.rdata, 32'hDE22BE44);
    check_eq("oorw_cnt", cnt_a, 8'd2);
    req_a = '0;

    // Read-only instance
    req_b = mk(32'h4, 1'b1, 4'hF, 32'h12345678, 4'd2); tick;
    check_eq("ro_wr_err", rsp_b.r.err, 1'b1);
    check_eq("ro_wr_rdata", rsp_b.r.rdata, 32'h0);
    check_eq("ro_wr_rid", rsp_b.r.rid, 4'd2);
    req_b = mk(32'h4, 1'b0, 4'h0, 32'h0, 4'd3); tick;
    check_eq("ro_rd_rdata", rsp_b.r.rdata, 32'hDEADBEEF);
    check_eq("ro_rd_err", rsp_b.r.err, 1'b0);
    check_eq("ro_cnt", cnt_b, 8'd1);
    req_b = '0;

    // Latency 3 streaming: responses in cycles 2..5 of this loop
    for (int i = 0; i < 7; i++) begin
      req_c = (i < 4) ? mk(32'(i * 4), 1'b0, 4'h0, 32'h0, 4'(i)) : '0;
      tick;
      check_eq($sformatf("lat3_rvalid_%0d", i), rsp_c.rvalid, (i >= 2 && i <= 5) ? 1'b1 : 1'b0);
      if (i >= 2 && i <= 5) begin
        check_eq($sformatf("lat3_rid_%0d", i), rsp_c.r.rid, 4'(i - 2));
        check_eq($sformatf("lat3_rdata_%0d", i), rsp_c.r.rdata, 32'hDEADBEEF);
      end
    end

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      req_c = mk(32'h40, 1'b0, 4'h0, 32'h0, 4'(i));
      tick;
    end
    req_c = '0;
    for (int i = 0; i < 5; i++) tick;
    check_eq("sat_cnt", cnt_c, 2'd3);

    // Clear coincident with an error response
    req_c = mk(32'h80, 1'b0, 4'h0, 32'h0, 4'd1); tick;
    req_c = '0; tick; tick;
    check_eq("clr_rvalid", rsp_c.rvalid, 1'b1);
    check_eq("clr_err", rsp_c.r.err, 1'b1);
    check_eq("clr_cnt_before", cnt_c, 2'd3);
    clr_c = 1'b1; tick;
    clr_c = 1'b0;
    check_eq("clr_cnt_after", cnt_c, 2'd0);

    // Reset with two responses in flight
    req_c = mk(32'h0, 1'b0, 4'h0, 32'h0, 4'd1); tick;
    req_c = mk(32'h4, 1'b0, 4'h0, 32'h0, 4'd2); tick;
    req_c = '0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rvalid", rsp_c.rvalid, 1'b0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq($sformatf("post_rst_rvalid_%0d", i), rsp_c.rvalid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/user_obi_mem.md
Name: user_obi_mem

Overview:
- Parametrised OBI subordinate memory for the user domain; successor to the fixed single-cycle, read-only, 16-word user-domain ROM.
- Adds configurable depth, configurable read latency, byte-enabled writes (or read-only mode), range checking and a saturating error counter.
- Sits behind the user-domain OBI demux as a scratchpad or lookup table; one request accepted per cycle, responses returned in order.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration (DataWidth, AddrWidth, IdWidth).
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- NumWords, 16, memory depth in DataWidth-bit words; power of two, 2..256.
- Latency, 1, cycles from request acceptance to rvalid; legal range 1..4.
- ReadOnly, 1'b0, 1 = writes are rejected with err and do not modify memory.
- InitWord, 32'hDEADBEEF, value loaded into every word on reset.
- CntWidth, 8, width of the error counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- obi_req_i  in  obi_req_t  OBI A-channel request
- obi_rsp_o  out  obi_rsp_t  OBI gnt and R-channel response
- err_cnt_o  out  CntWidth  saturating count of error responses issued
- clr_cnt_i  in  1  synchronous clear of err_cnt_o

Behaviour:
- Reset is synchronous: on a clk_i edge with rst_ni=0:
  - every memory word is set to InitWord;
  - the response pipeline is emptied (all stage valids 0);
  - err_cnt_o is set to 0.
- While rst_ni=0, outputs are rvalid=0, rdata=0, rid=0, err=0, r_optional=0 and err_cnt_o=0. gnt still mirrors req.
- Grant: gnt = req combinationally, with no backpressure. A request is accepted in any cycle where req=1 and rst_ni=1.
- Word index: addr[$clog2(NumWords)+1:2]. Address bits [1:0] are ignored.
- Range check: a request is out of range if any addr bit above bit $clog2(NumWords)+1 is set, after subtracting nothing. The block is mapped at offset 0 of its decoded window.
- Error conditions, evaluated at acceptance:
  - err = out-of-range OR (we AND ReadOnly);
  - an error request causes no memory update and returns rdata = 0.
- Writes: on acceptance with we=1 and no error, the write commits at that clock edge. For each set bit i of be, byte i of the word is replaced by wdata byte i. be=0 is a legal no-op write. The write response carries rdata=0 and err=0.
- Reads: the word is sampled at the acceptance edge, using memory contents after any write committed on earlier edges. A read in the cycle after a write to the same word returns the new data.
- Pipeline:
  - each accepted request enters an in-order delay line of Latency stages carrying {valid, rid, err, rdata};
  - rvalid is asserted exactly Latency cycles after the acceptance edge;
  - back-to-back requests produce back-to-back responses;
  - the rid of each response equals the aid of its request.
- Latency=1 is cycle-equivalent to the legacy ROM: response in the cycle after acceptance.
- r_optional is always '0.
- Error counter:
  - increments by 1 on every cycle where rvalid=1 and err=1;
  - saturates at 2^CntWidth-1 with no wrap;
  - clr_cnt_i=1 forces the counter to 0 and takes priority over an increment in the same cycle.
- Mid-operation reset: in-flight responses are discarded and never emitted. The OBI manager is reset by the same signal.
- Elaboration: fatal assertion if Latency is not in 1..4, if NumWords is not a power of two, or if DataWidth is not 32.

Decomposition:
- New package user_mem_pkg:
  - localparam MaxLatency = 4;
  - typedef rsp_stage_t = struct {valid, id, err, data}, parametrised via a DataWidth/IdWidth-generic pattern;
  - function word_idx() to extract the word index.
- Sub-module user_obi_rsp_pipe: a generic Latency-deep, resettable, in-order shift register of rsp_stage_t.
- The top level holds only the memory array, decode/error logic and the error counter.

Test Plan:
- Reset then read: read addr 0x0 and 0x3C (NumWords=16, Latency=1) -> rvalid one cycle later, rdata=0xDEADBEEF, err=0, rid = aid.
- Byte-enable write then read: write 0x8 with wdata=0x11223344, be=4'b0101, then read 0x8 next cycle -> rdata=0xDE22BE44.
- Out-of-range read: read addr 0x40 with NumWords=16 -> err=1, rdata=0, err_cnt_o goes from 0 to 1 one cycle after rvalid.
- Read-only mode: with ReadOnly=1, write 0x4 then read 0x4 -> write gets err=1; read returns 0xDEADBEEF.
- Streaming at Latency=3: four back-to-back reads with aid 0..3 -> rvalid high for four consecutive cycles starting 3 cycles after the first accept, rid sequence 0,1,2,3.
- Counter saturation and clear, plus reset mid-flight:
  - CntWidth=2: five error requests -> err_cnt_o=3; clr_cnt_i coincident with an error response -> 0.
  - rst_ni low for one cycle with 2 responses in flight -> no rvalid afterwards.
